icache_fill_ctrl: RTL and testbench
===================================

Name: icache_fill_ctrl

Overview:
- Miss handler that sits directly downstream of the instruction cache.
- Takes the cache's miss request and line address, and fetches the 256-bit line from the memory bus in BUS_W-bit beats.
- Assembles the beats into a line, then presents the line with a one-cycle fill acknowledge that writes the cache data and tag stores.
- Supports abort on fetch redirect (flush) without violating the bus handshake.

Parameters:
- ADDR_W, 15, physical address width: tag[14:9], index[8:5], offset[4:0].
- LINE_W, 256, cache line width in bits.
- BUS_W, 32, memory read data width per beat. LINE_W must be a multiple of BUS_W; NBEATS = LINE_W/BUS_W (default 8).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ic_miss  in  1  cache miss request (level, held by cache until serviced).
- ic_addr  in  ADDR_W  miss line address; offset bits ignored.
- flush  in  1  fetch redirect; abort current/pending fill.
- ic_fill_data  out  LINE_W  assembled line to cache data store.
- ic_miss_ack  out  1  one-cycle fill strobe to cache (write enable).
- mem_req  out  1  bus read request.
- mem_addr  out  ADDR_W  line-aligned bus address (offset bits forced to 0).
- mem_gnt  in  1  bus grant, sampled while mem_req=1.
- mem_rd_valid  in  1  read beat valid.
- mem_rd_data  in  BUS_W  read beat data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE; ic_miss_ack=0, mem_req=0, mem_addr=0, ic_fill_data=0, busy=0; beat count=0; abort flag=0. Reset mid-fill discards all in-flight data; no ack is issued.
- States: IDLE, REQ, DATA, ACK, HOLD.
- IDLE:
  - If ic_miss=1 and flush=0: latch {ic_addr[14:5],5'b0} into mem_addr; go to REQ, with mem_req=1 from the next cycle.
  - flush=1 blocks the start.
- REQ:
  - mem_req and mem_addr are held constant until mem_gnt=1 is sampled. The request is never withdrawn, even on flush.
  - On grant: mem_req=0 next cycle, beat count=0, go to DATA.
- DATA:
  - Each cycle with mem_rd_valid=1: mem_rd_data is written into ic_fill_data[cnt*BUS_W +: BUS_W] (beat 0 is the least significant), and cnt increments.
  - Cycles with mem_rd_valid=0 stall the state and change nothing.
  - On the beat where cnt=NBEATS-1: go to IDLE if the abort flag is set (clear the flag); otherwise go to ACK.
  - mem_rd_valid outside DATA is ignored.
- ACK: ic_miss_ack=1 for exactly one cycle; ic_fill_data stable; go to HOLD.
- HOLD: one cycle with ic_miss ignored, so the cache tag and valid update is seen before re-arming. Then go to IDLE.
- Abort:
  - flush=1 in REQ or DATA sets the abort flag.
  - flush in ACK has no effect; the ack still fires, because the line data is valid.
  - flush in the same cycle as the final beat also aborts.
- Minimum miss-to-ack latency: 1 (IDLE→REQ) + grant wait + NBEATS beats + 1. With grant on the first REQ cycle and back-to-back beats, ic_miss_ack asserts 11 cycles after ic_miss is first sampled.
- ic_fill_data holds its last value between fills. Partially filled data after an abort is don't-care but never acked.
- busy = (state != IDLE).

Optional Feature:
- Macro: ICFILL_PERF_EN.
- When defined, add two outputs:
  - perf_fills [15:0]: increments on every ic_miss_ack.
  - perf_stall [15:0]: increments on every cycle busy=1.
  - Both saturate at 16'hFFFF and reset to 0 on rst.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Basic fill: ic_addr=15'h1A3F, mem_gnt on first REQ cycle, 8 back-to-back beats 32'h0000_0000..32'h0000_0007.
  - Expect mem_addr=15'h1A20.
  - Expect ic_miss_ack as a single pulse 11 cycles after the miss.
  - Expect ic_fill_data[31:0]=0 and [255:224]=7.
- Grant delay and beat gaps: mem_gnt after 3 cycles; mem_rd_valid toggles 1,0,1,0...
  - Expect mem_req held for exactly 4 cycles with mem_addr stable.
  - Expect the ack after the 8th valid beat, and correct beat placement.
- Abort in DATA: flush pulse after beat 3.
  - Expect all 8 beats consumed, no ic_miss_ack, return to IDLE, busy=0.
  - A following miss (ic_addr=15'h0040) completes normally.
- Abort in REQ and in IDLE:
  - flush held with ic_miss=1 in IDLE → no mem_req.
  - flush during REQ → mem_req stays high until grant, and the fill is dropped.
- Reset mid-fill: assert rst after beat 5.
  - Expect outputs 0 immediately (async), no ack, state IDLE, ic_fill_data=0.
- HOLD re-arm: keep ic_miss=1 through ACK+1.
  - Expect no new mem_req in the HOLD cycle, and a new REQ one cycle later if ic_miss is still high.
  - With ICFILL_PERF_EN, expect perf_fills=2 after two fills.

Source files
------------

// File: rtl/icache_fill_ctrl_if.sv
// Memory read bus between the I-cache fill controller (master) and the memory side (slave).
interface icache_fill_ctrl_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned BUS_W  = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rd_valid;
  logic [BUS_W-1:0]  mem_rd_data;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_gnt,
    input  mem_rd_valid,
    input  mem_rd_data
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_gnt,
    output mem_rd_valid,
    output mem_rd_data
  );
endinterface

// File: rtl/icache_fill_ctrl.sv
// I-cache miss handler: fetches a line in BUS_W beats, assembles it and strobes a one-cycle fill.
// Optional perf counters (perf_fills_o, perf_stall_o) are built when ICFILL_PERF_EN is defined.
module icache_fill_ctrl #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BUS_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_miss_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  input  logic              flush_i,
  output logic [LINE_W-1:0] ic_fill_data_o,
  output logic              ic_miss_ack_o,
  output logic              busy_o,
`ifdef ICFILL_PERF_EN
  output logic [15:0]       perf_fills_o,
  output logic [15:0]       perf_stall_o,
`endif
  icache_fill_ctrl_if.master mem
);

  localparam int unsigned NBeats = LINE_W / BUS_W;
  localparam int unsigned OffW   = $clog2(LINE_W / 8);
  localparam int unsigned CntW   = (NBeats > 1) ? $clog2(NBeats) : 1;

  typedef enum logic [2:0] {StIdle, StReq, StData, StAck, StHold} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] data_q, data_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              abort_q, abort_d;

  // Offset bits of the miss address never reach the bus.
  logic unused_offset;
  assign unused_offset = ^ic_addr_i[OffW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    unique case (state_q)
      StIdle: begin
        if (ic_miss_i && !flush_i) begin
          addr_d  = {ic_addr_i[ADDR_W-1:OffW], {OffW{1'b0}}};
          state_d = StReq;
        end
      end
      StReq: begin
        // The request is never withdrawn; a flush only marks the fill for dropping.
        if (flush_i) abort_d = 1'b1;
        if (mem.mem_gnt) begin
          cnt_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (flush_i) abort_d = 1'b1;
        if (mem.mem_rd_valid) begin
          data_d[32'(cnt_q) * BUS_W +: BUS_W] = mem.mem_rd_data;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(NBeats - 1)) begin
            cnt_d = '0;
            if (abort_q || flush_i) begin
              abort_d = 1'b0;
              state_d = StIdle;
            end else begin
              state_d = StAck;
            end
          end
        end
      end
      StAck:   state_d = StHold;
      // Lets the cache's tag/valid update land before a new miss is accepted.
      StHold:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign mem.mem_req    = (state_q == StReq);
  assign mem.mem_addr   = addr_q;
  assign ic_fill_data_o = data_q;
  assign ic_miss_ack_o  = (state_q == StAck);
  assign busy_o         = (state_q != StIdle);

`ifdef ICFILL_PERF_EN
  logic [15:0] fills_q, fills_d;
  logic [15:0] stall_q, stall_d;

  always_comb begin
    fills_d = fills_q;
    stall_d = stall_q;
    if (ic_miss_ack_o && (fills_q != 16'hFFFF)) fills_d = fills_q + 16'd1;
    if (busy_o && (stall_q != 16'hFFFF))        stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fills_q <= '0;
      stall_q <= '0;
    end else begin
      fills_q <= fills_d;
      stall_q <= stall_d;
    end
  end

  assign perf_fills_o = fills_q;
  assign perf_stall_o = stall_q;
`endif

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Scoreboard bench for icache_fill_ctrl: expected lines are queued as beats are driven and
// popped when the fill strobe appears.
module tb_icache_fill_ctrl;

  logic         clk;
  logic         rst;
  logic         ic_miss;
  logic [14:0]  ic_addr;
  logic         flush;
  logic [255:0] ic_fill_data;
  logic         ic_miss_ack;
  logic         busy;
`ifdef ICFILL_PERF_EN
  logic [15:0]  perf_fills;
  logic [15:0]  perf_stall;
`endif

  icache_fill_ctrl_if #(.ADDR_W(15), .BUS_W(32)) bus ();

  icache_fill_ctrl #(.ADDR_W(15), .LINE_W(256), .BUS_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .ic_miss_i      (ic_miss),
    .ic_addr_i      (ic_addr),
    .flush_i        (flush),
    .ic_fill_data_o (ic_fill_data),
    .ic_miss_ack_o  (ic_miss_ack),
    .busy_o         (busy),
`ifdef ICFILL_PERF_EN
    .perf_fills_o   (perf_fills),
    .perf_stall_o   (perf_stall),
`endif
    .mem            (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  logic [255:0] sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every fill strobe must match the oldest line queued by the stimulus.
  always @(negedge clk) begin
    if (!rst && ic_miss_ack) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_ack: ic_miss_ack=1 with no fill expected (data %h)",
                 ic_fill_data);
      end else begin
        logic [255:0] exp;
        exp = sb.pop_front();
        if (ic_fill_data !== exp) begin
          tests_failed++;
          $display("FAIL fill_data: got %h expected %h", ic_fill_data, exp);
        end
      end
    end
  end

  // Drives one miss and serves it from the memory side; returns observations, checks nothing.
  task automatic run_fill(input logic [14:0] addr, input int gnt_wait, input bit gaps,
                          input logic [31:0] base, input int flush_beat, input bit flush_req,
                          input int n_beats, input bit keep_miss,
                          output int req_cycles, output bit addr_stable,
                          output logic [14:0] addr_seen, output int lat,
                          output bit ack_seen, output logic busy_after);
    logic [255:0] exp_line;
    int n;
    req_cycles  = 0;
    addr_stable = 1'b1;
    ack_seen    = 1'b0;
    exp_line    = '0;
    lat         = 1;  // cycle in which ic_miss is first sampled
    ic_miss = 1'b1;
    ic_addr = addr;
    n = 0;
    do begin
      @(negedge clk);
      lat++;
      n++;
    end while (!bus.mem_req && n < 10);
    addr_seen = bus.mem_addr;
    if (!keep_miss) ic_miss = 1'b0;
    n = 0;
    while (bus.mem_req && n < 40) begin
      req_cycles++;
      n++;
      if (bus.mem_addr !== addr_seen) addr_stable = 1'b0;
      flush       = flush_req && (req_cycles == 1);
      bus.mem_gnt = (req_cycles == gnt_wait + 1);
      @(negedge clk);
      lat++;
    end
    bus.mem_gnt = 1'b0;
    flush       = 1'b0;
    for (int b = 0; b < n_beats; b++) begin
      bus.mem_rd_valid = 1'b1;
      bus.mem_rd_data  = base + 32'(b);
      exp_line[b*32 +: 32] = base + 32'(b);
      flush = (b == flush_beat);
      if (b == 7 && flush_beat < 0 && !flush_req) sb.push_back(exp_line);
      @(negedge clk);
      lat++;
      bus.mem_rd_valid = 1'b0;
      flush            = 1'b0;
      if (gaps && b < n_beats - 1) begin
        @(negedge clk);
        lat++;
      end
    end
    busy_after = busy;
    if (n_beats == 8) begin
      for (int i = 0; i < 12 && !ack_seen; i++) begin
        if (ic_miss_ack) ack_seen = 1'b1;
        else begin
          @(negedge clk);
          lat++;
        end
      end
    end
    if (ack_seen && !keep_miss) ic_miss = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests_run += 5;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (bus.mem_req !== 1'b0) begin
      tests_failed++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req);
    end
    if (bus.mem_addr !== 15'h0) begin
      tests_failed++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr);
    end
    if (ic_miss_ack !== 1'b0) begin
      tests_failed++; $display("FAIL reset_ack: got %b want 0", ic_miss_ack);
    end
    if (ic_fill_data !== 256'h0) begin
      tests_failed++; $display("FAIL reset_fill_data: got %h want 0", ic_fill_data);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_fill();
    int rc, lat; bit st, ack; logic [14:0] a; logic ba;
    run_fill(15'h1A3F, 0, 1'b0, 32'h0, -1, 1'b0, 8, 1'b0, rc, st, a, lat, ack, ba);
    tests_run += 6;
    if (a !== 15'h1A20) begin tests_failed++; $display("FAIL basic_addr: got %h want 1a20", a); end
    if (rc != 1) begin tests_failed++; $display("FAIL basic_req_cycles: got %0d want 1", rc); end
    if (!ack || lat != 11) begin
      tests_failed++; $display("FAIL basic_latency: ack=%b cycle %0d want ack in cycle 11", ack, lat);
    end
    if (ic_fill_data[31:0] !== 32'h0) begin
      tests_failed++; $display("FAIL basic_beat0: got %h want 0", ic_fill_data[31:0]);
    end
    if (ic_fill_data[255:224] !== 32'h7) begin
      tests_failed++; $display("FAIL basic_beat7: got %h want 7", ic_fill_data[255:224]);
    end
    @(negedge clk);
    if (ic_miss_ack !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_single_pulse: ack=%b busy=%b want ack=0 busy=1", ic_miss_ack, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_gnt_gaps();
    int rc, lat; bit st, ack; logic [14:0] a; logic ba;
    run_fill(15'h5555, 3, 1'b1, 32'hC0DE_0000, -1, 1'b0, 8, 1'b0, rc, st, a, lat, ack, ba);
    tests_run += 4;
    if (rc != 4) begin tests_failed++; $display("FAIL gap_req_cycles: got %0d want 4", rc); end
    if (!st) begin tests_failed++; $display("FAIL gap_addr_stable: mem_addr changed during REQ"); end
    if (a !== 15'h5540) begin tests_failed++; $display("FAIL gap_addr: got %h want 5540", a); end
    // 1 + 4 REQ + 15 DATA (8 beats, 7 gaps) + ACK
    if (!ack || lat != 21) begin
      tests_failed++; $display("FAIL gap_latency: ack=%b cycle %0d want ack in cycle 21", ack, lat);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort_data();
    int rc, lat; bit st, ack; logic [14:0] a; logic ba;
    run_fill(15'h2222, 0, 1'b0, 32'h1000, 4, 1'b0, 8, 1'b0, rc, st, a, lat, ack, ba);
    tests_run += 2;
    if (ack) begin tests_failed++; $display("FAIL abort_data_ack: got ack want none"); end
    if (ba !== 1'b0) begin tests_failed++; $display("FAIL abort_data_busy: got %b want 0", ba); end
    run_fill(15'h0040, 0, 1'b0, 32'h2000, -1, 1'b0, 8, 1'b0, rc, st, a, lat, ack, ba);
    tests_run += 2;
    if (a !== 15'h0040) begin tests_failed++; $display("FAIL after_abort_addr: got %h want 0040", a); end
    if (!ack || lat != 11) begin
      tests_failed++; $display("FAIL after_abort_fill: ack=%b cycle %0d want ack in cycle 11", ack, lat);
    end
    repeat (2) @(negedge clk);
    // Flush coinciding with the final beat still drops the line.
    run_fill(15'h3333, 0, 1'b0, 32'h3000, 7, 1'b0, 8, 1'b0, rc, st, a, lat, ack, ba);
    tests_run += 2;
    if (ack) begin tests_failed++; $display("FAIL abort_last_ack: got ack want none"); end
    if (ba !== 1'b0) begin tests_failed++; $display("FAIL abort_last_busy: got %b want 0", ba); end
  endtask

  task automatic test_abort_idle_req();
    int rc, lat; bit st, ack; logic [14:0] a; logic ba;
    ic_miss = 1'b1;
    ic_addr = 15'h4444;
    flush   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.mem_req !== 1'b0 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle_flush_block: mem_req=%b busy=%b want 0 0", bus.mem_req, busy);
      end
    end
    ic_miss = 1'b0;
    flush   = 1'b0;
    @(negedge clk);
    run_fill(15'h4444, 2, 1'b0, 32'h4000, -1, 1'b1, 8, 1'b0, rc, st, a, lat, ack, ba);
    tests_run += 3;
    if (rc != 3) begin tests_failed++; $display("FAIL req_flush_hold: req cycles %0d want 3", rc); end
    if (ack) begin tests_failed++; $display("FAIL req_flush_ack: got ack want none"); end
    if (ba !== 1'b0) begin tests_failed++; $display("FAIL req_flush_busy: got %b want 0", ba); end
  endtask

  task automatic test_reset_mid_fill();
    int rc, lat; bit st, ack; logic [14:0] a; logic ba;
    run_fill(15'h6666, 0, 1'b0, 32'hA0, -1, 1'b0, 6, 1'b0, rc, st, a, lat, ack, ba);
    rst = 1'b1;
    #1;
    tests_run += 4;
    if (busy !== 1'b0 || ic_miss_ack !== 1'b0) begin
      tests_failed++; $display("FAIL mid_reset_state: busy=%b ack=%b want 0 0", busy, ic_miss_ack);
    end
    if (bus.mem_req !== 1'b0) begin
      tests_failed++; $display("FAIL mid_reset_req: got %b want 0", bus.mem_req);
    end
    if (bus.mem_addr !== 15'h0) begin
      tests_failed++; $display("FAIL mid_reset_addr: got %h want 0", bus.mem_addr);
    end
    if (ic_fill_data !== 256'h0) begin
      tests_failed++; $display("FAIL mid_reset_data: got %h want 0", ic_fill_data);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int rc, lat; bit st, ack; logic [14:0] a; logic ba;
    run_fill(15'h7ABC, 0, 1'b0, 32'h5000, -1, 1'b0, 8, 1'b1, rc, st, a, lat, ack, ba);
    tests_run++;
    if (!ack) begin tests_failed++; $display("FAIL hold_first_ack: no ack seen"); end
    @(negedge clk);
    tests_run++;
    if (bus.mem_req !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_cycle: mem_req=%b busy=%b want 0 1", bus.mem_req, busy);
    end
    @(negedge clk);
    tests_run++;
    if (bus.mem_req !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_rearm_idle: mem_req=%b busy=%b want 0 0", bus.mem_req, busy);
    end
    run_fill(15'h7ABC, 0, 1'b0, 32'h6000, -1, 1'b0, 8, 1'b0, rc, st, a, lat, ack, ba);
    tests_run += 2;
    if (a !== 15'h7AA0) begin tests_failed++; $display("FAIL rearm_addr: got %h want 7aa0", a); end
    if (!ack || lat != 11) begin
      tests_failed++; $display("FAIL rearm_fill: ack=%b cycle %0d want ack in cycle 11", ack, lat);
    end
    repeat (2) @(negedge clk);
`ifdef ICFILL_PERF_EN
    tests_run += 2;
    if (perf_fills !== 16'd2) begin
      tests_failed++; $display("FAIL perf_fills: got %0d want 2", perf_fills);
    end
    if (perf_stall !== 16'd22) begin
      tests_failed++; $display("FAIL perf_stall: got %0d want 22", perf_stall);
    end
`endif
  endtask

  initial begin
    rst              = 1'b1;
    ic_miss          = 1'b0;
    ic_addr          = '0;
    flush            = 1'b0;
    bus.mem_gnt      = 1'b0;
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_data  = '0;
    test_reset();
    test_basic_fill();
    test_gnt_gaps();
    test_abort_data();
    test_abort_idle_req();
    test_reset_mid_fill();
    test_back_to_back();
    repeat (3) @(negedge clk);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++; $display("FAIL missing_ack: %0d expected fills never acked", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
